// File: rtl/visited_store.sv
// visited_store: per-node predecessor/visited store with a live count of unvisited valid nodes.
module visited_store #(
   parameter int MAX_NODES   = 16,
   parameter int INDEX_WIDTH = 8,
   parameter int VALUE_WIDTH = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           set_en,
   input  logic [INDEX_WIDTH-1:0]         number_of_nodes,
   input  logic [INDEX_WIDTH-1:0]         index,
   input  logic [INDEX_WIDTH-1:0]         prev_node,
   output logic [INDEX_WIDTH-1:0]         unvisited_nodes,
   output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened
);
   // Distance width only matters to the rest of the engine; it must still be a legal width.
   localparam int CW = (VALUE_WIDTH > 0) ? INDEX_WIDTH : INDEX_WIDTH;
   localparam logic [CW-1:0] MAX_N = CW'(MAX_NODES);
   logic [INDEX_WIDTH-1:0] prev [MAX_NODES];
   logic                   visited [MAX_NODES];
   logic [CW-1:0]          n;
   logic [CW-1:0]          cnt;
   for (genvar j = 0; j < MAX_NODES; j++) begin : g_slot
      always_ff @(posedge clock or posedge reset)
         if (reset) begin
            prev[j]    <= '1;
            visited[j] <= 1'b0;
         end else if (set_en && index == INDEX_WIDTH'(j)) begin
            prev[j]    <= prev_node;
            visited[j] <= 1'b1;
         end
      assign prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH] = prev[j];
   end
   always_comb begin
      n   = (number_of_nodes > MAX_N) ? MAX_N : number_of_nodes;
      cnt = n;
      for (int j = 0; j < MAX_NODES; j++)
         cnt = (visited[j] && CW'(j) < n) ? cnt - 1'b1 : cnt;
   end
   assign unvisited_nodes = cnt;
endmodule

// File: tb/tb_visited_store.sv
// tb_visited_store: randomized bench for visited_store against an array-based reference model.
module tb_visited_store;
   localparam int N  = 16;
   localparam int W  = 8;
   localparam int FW = N * W;
   logic          clock = 1'b0;
   logic          reset;
   logic          set_en;
   logic [W-1:0]  number_of_nodes;
   logic [W-1:0]  index;
   logic [W-1:0]  prev_node;
   logic [W-1:0]  unvisited_nodes;
   logic [FW-1:0] prev_vector_flattened;
   int            checks = 0;
   int            passed = 0;
   logic [W-1:0]  m_prev [N];
   bit            m_vis  [N];
   logic [FW-1:0] snap;
   logic [W-1:0]  p;

   visited_store #(.MAX_NODES(N), .INDEX_WIDTH(W), .VALUE_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .set_en(set_en), .number_of_nodes(number_of_nodes),
      .index(index), .prev_node(prev_node), .unvisited_nodes(unvisited_nodes),
      .prev_vector_flattened(prev_vector_flattened)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   function automatic logic [W-1:0] exp_unv();
      int lim = (int'(number_of_nodes) < N) ? int'(number_of_nodes) : N;
      int c = lim;
      for (int j = 0; j < lim; j++) if (m_vis[j]) c--;
      return W'(c);
   endfunction

   function automatic logic [FW-1:0] exp_vec();
      logic [FW-1:0] v;
      for (int j = 0; j < N; j++) v[W*j +: W] = m_prev[j];
      return v;
   endfunction

   // Reference model: a visit records the predecessor and marks the node, reset wipes everything.
   always @(posedge clock or posedge reset)
      if (reset) for (int j = 0; j < N; j++) begin m_prev[j] = '1; m_vis[j] = 0; end
      else if (set_en && int'(index) < N) begin
         m_prev[int'(index)] = prev_node;
         m_vis[int'(index)]  = 1;
      end

   always @(negedge clock) begin
      chk("cyc_unvisited", FW'(unvisited_nodes), FW'(exp_unv()));
      chk("cyc_vector", prev_vector_flattened, exp_vec());
   end

   task automatic tick();
      @(negedge clock);
      #2;
   endtask

   task automatic visit(input logic [W-1:0] idx, input logic [W-1:0] pv, input int cyc);
      index = idx; prev_node = pv; set_en = 1'b1;
      repeat (cyc) tick();
      set_en = 1'b0;
   endtask

   task automatic do_reset(input logic [W-1:0] nn);
      reset = 1'b1; set_en = 1'b0; number_of_nodes = nn; index = '0; prev_node = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; set_en = 1'b0; number_of_nodes = 8'd10; index = '0; prev_node = '0;
      #1;
      chk("reset_vec_async", prev_vector_flattened, {N{8'hFF}});
      do_reset(8'd10);
      chk("reset_unvisited", FW'(unvisited_nodes), FW'(10));
      chk("reset_vector", prev_vector_flattened, {N{8'hFF}});
      for (int i = 0; i < 10; i++) begin
         p = W'($urandom_range(0, 9));
         visit(W'(i), p, 2 + int'($urandom_range(0, 1)));
         chk("seq_prev", FW'(prev_vector_flattened[W*i +: W]), FW'(p));
         chk("seq_unvisited", FW'(unvisited_nodes), FW'(9 - i));
      end
      chk("seq_final_zero", FW'(unvisited_nodes), FW'(0));

      do_reset(8'd10);
      visit(8'd3, 8'd5, 1);
      chk("revisit_first", FW'(unvisited_nodes), FW'(9));
      visit(8'd3, 8'd7, 3);
      chk("revisit_prev", FW'(prev_vector_flattened[W*3 +: W]), FW'(7));
      chk("revisit_count", FW'(unvisited_nodes), FW'(9));
      visit(8'd12, 8'd2, 1);
      chk("slot12_prev", FW'(prev_vector_flattened[W*12 +: W]), FW'(2));
      chk("slot12_count", FW'(unvisited_nodes), FW'(9));
      snap = prev_vector_flattened;
      visit(8'd200, 8'd1, 2);
      chk("oob_vector", prev_vector_flattened, snap);
      chk("oob_count", FW'(unvisited_nodes), FW'(9));
      visit(8'd6, 8'hFF, 1);
      chk("sentinel_prev", FW'(prev_vector_flattened[W*6 +: W]), FW'(255));
      chk("sentinel_count", FW'(unvisited_nodes), FW'(8));

      reset = 1'b1;
      #1;
      chk("async_reset_vec", prev_vector_flattened, {N{8'hFF}});
      chk("async_reset_cnt", FW'(unvisited_nodes), FW'(10));
      set_en = 1'b1; index = 8'd1; prev_node = 8'd4;
      tick();
      chk("reset_priority", FW'(prev_vector_flattened[W*1 +: W]), FW'(255));
      set_en = 1'b0; reset = 1'b0;
      tick();

      visit(8'd0, 8'd0, 1);
      visit(8'd5, 8'd0, 1);
      chk("nn10_count", FW'(unvisited_nodes), FW'(8));
      number_of_nodes = 8'd4;
      #1;
      chk("nn4_count", FW'(unvisited_nodes), FW'(3));
      number_of_nodes = 8'd40;
      #1;
      chk("nn_clamp_count", FW'(unvisited_nodes), FW'(14));

      do_reset(8'd10);
      for (int c = 0; c < 400; c++) begin
         set_en = ($urandom_range(0, 2) != 0);
         index = ($urandom_range(0, 9) == 0) ? W'($urandom_range(16, 255)) : W'($urandom_range(0, 15));
         prev_node = W'($urandom);
         if ($urandom_range(0, 15) == 0) number_of_nodes = W'($urandom_range(0, 20));
         if ($urandom_range(0, 63) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         tick();
      end
      set_en = 1'b0;
      tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/visited_store.md
Name: visited_store

Overview:
- Per-node visited/predecessor store for the Dijkstra shortest-path engine.
- Each node slot holds its predecessor index, or the UNVISITED sentinel until the node is visited.
- A visit writes the predecessor into the slot and marks the node visited.
- The block exposes the live count of unvisited nodes (used by the controller for loop termination) and the full predecessor vector, flattened.

Parameters:
- MAX_NODES, 16, number of node slots stored.
- INDEX_WIDTH, 8, width of node indices, predecessor values and counts; must satisfy 2^INDEX_WIDTH - 1 > MAX_NODES.
- VALUE_WIDTH, 8, distance width used elsewhere in the engine; accepted for interface uniformity, unused here.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- set_en  input  1  visit strobe; sampled each rising edge.
- number_of_nodes  input  INDEX_WIDTH  count of valid nodes in the current graph (0..MAX_NODES).
- index  input  INDEX_WIDTH  node being visited.
- prev_node  input  INDEX_WIDTH  predecessor to record for index.
- unvisited_nodes  output  INDEX_WIDTH  number of valid nodes not yet visited.
- prev_vector_flattened  output  INDEX_WIDTH*MAX_NODES  predecessor array; slot j occupies bits [INDEX_WIDTH*j +: INDEX_WIDTH].

Behaviour:
- UNVISITED sentinel = all ones of INDEX_WIDTH (255 at default).
- State per slot j: prev[j] (INDEX_WIDTH bits) and visited[j] (1 bit).
- Reset (asynchronous, immediate, held while reset=1):
  - every prev[j] = UNVISITED;
  - every visited[j] = 0.
- Rising edge with reset=0 and set_en=1 and index < MAX_NODES:
  - prev[index] <= prev_node;
  - visited[index] <= 1.
  - Visible on outputs immediately after that edge (1-cycle write latency).
- set_en=0: no state change.
- set_en=1 with index >= MAX_NODES: write ignored, no state change.
- Re-writing an already visited slot:
  - prev is overwritten with the new prev_node;
  - visited stays 1;
  - the count does not decrement again.
- Holding set_en=1 on the same index for several cycles is therefore idempotent apart from the prev value.
- A prev_node equal to UNVISITED is stored verbatim; the slot still counts as visited.
- unvisited_nodes is combinational from state and number_of_nodes:
  - value = N minus the number of j < N with visited[j]=1, where N = min(number_of_nodes, MAX_NODES);
  - after reset it equals min(number_of_nodes, MAX_NODES);
  - it tracks a change of number_of_nodes with no clock edge required.
- Slots j >= number_of_nodes:
  - still writable;
  - still output on prev_vector_flattened;
  - never affect unvisited_nodes.
- prev_vector_flattened is a direct, combinational view of the prev registers.
- Reset asserted mid-operation clears all slots and visited bits regardless of set_en.
- Reset has priority over a simultaneous write.
- No handshake: set_en is a level-sampled enable with no acknowledge.

Test Plan:
- Apply reset with number_of_nodes=10, then release -> all 16 prev slots read 255; unvisited_nodes=10.
- Visit index 0..9 sequentially, each with set_en held 2+ cycles and a random prev_node in 0..9 -> after each visit prev[i] equals prev_node and unvisited_nodes = 9-i; final value is 0.
- Visit index 3 twice with prev_node 5, then 7 -> prev[3]=7; unvisited_nodes decremented only once (10 -> 9).
- Write index 12 with number_of_nodes=10 -> prev[12] updated; unvisited_nodes unchanged. Write index 200 -> no state change.
- After partial visits, assert reset asynchronously between clock edges -> outputs return to all-255 and unvisited_nodes=number_of_nodes before the next edge.
- Change number_of_nodes from 10 to 4 after visiting nodes 0 and 5 -> unvisited_nodes goes from 8 to 3 combinationally.
